frame_pair_streamer: RTL and testbench
======================================

# frame_pair_streamer

Raster-order source for the pyramidal optical-flow core's pixel input. On `start` it reads a current/previous frame pair from two synchronous-read frame buffers through a shared address and emits one `pixel_curr`/`pixel_prev` pair per cycle with `pixel_valid`, plus start-of-frame, end-of-line and end-of-frame markers. It sits between the frame-buffer BRAMs and `optical_flow_top_pyramidal` and replaces bench-side streaming in system builds.

## Interface
Parameters:
- `IMAGE_WIDTH`, default 320: pixels per line.
- `IMAGE_HEIGHT`, default 240: lines per frame.
- `ADDR_WIDTH`, default 17: frame-buffer address width; must satisfy 2^ADDR_WIDTH ≥ IMAGE_WIDTH*IMAGE_HEIGHT.
- `H_BLANK`, default 16: idle cycles between lines. Used only with blanking compiled in.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin one frame pair. Sampled only in IDLE.
- `pause` in 1: when high, no new read is issued.
- `busy` out 1: frame streaming in progress.
- `done` out 1: one-cycle pulse after the last pixel.
- `mem_rd_en` out 1: read strobe to both buffers.
- `mem_addr` out ADDR_WIDTH: linear address `y*IMAGE_WIDTH+x`, shared by both buffers.
- `mem_curr_data` in 8: current-frame read data, valid exactly one cycle after `mem_rd_en`.
- `mem_prev_data` in 8: previous-frame read data, same timing.
- `pixel_curr`, `pixel_prev` out 8: output pixel pair.
- `pixel_valid` out 1: pixel pair valid this cycle.
- `pixel_sof` out 1: with pixel (0,0).
- `pixel_eol` out 1: with x = IMAGE_WIDTH-1.
- `pixel_eof` out 1: with the last pixel.

## Operation
- FSM states: IDLE, STREAM, BLANK (blanking builds only), DRAIN, DONE.
- IDLE:
  - `start`=1 → STREAM. Clear x, y and the address.
- STREAM:
  - Each cycle with `pause`=0: assert `mem_rd_en` with the current address, then advance x. At x wrap, advance y and clear x.
  - After the read of x = IMAGE_WIDTH-1 on a line other than the last → BLANK if compiled in.
  - After the read of the last address → DRAIN.
- BLANK:
  - Counts H_BLANK cycles with no reads, then returns to STREAM. `pause` does not stop the count.
- DRAIN:
  - Waits for in-flight reads to reach the output, then → DONE.
- DONE:
  - Asserts `done` for one cycle → IDLE.
- Read pipeline:
  - A read issued in cycle t yields the output registers in cycle t+2, with `pixel_valid`=1 and markers taken from a delayed copy of x/y.
  - Reads already issued always complete, including under `pause`.
- `start` outside IDLE is ignored.
- `busy`=1 in STREAM, BLANK and DRAIN; `busy`=0 in IDLE and DONE.
- Address is a linear counter incremented by 1 per read. No multiply. Never exceeds IMAGE_WIDTH*IMAGE_HEIGHT-1.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0. Reset mid-frame aborts immediately with no `done`. A read in flight at reset is discarded.
- With `start` high at edge 0: first `mem_rd_en` (addr 0) in cycle 1; first `pixel_valid` (with `pixel_sof`) in cycle 3.
- No blanking, no pause: `pixel_valid` is continuous for N = IMAGE_WIDTH*IMAGE_HEIGHT cycles (cycles 3..N+2); `pixel_eof` in cycle N+2; `done` in cycle N+3.
- With blanking: total span is N + (IMAGE_HEIGHT-1)*H_BLANK cycles. There is no blank after the last line.
- `pause` asserted in cycle t: no read in cycle t. `pixel_valid` drops in cycle t+2 and resumes 2 cycles after `pause` deasserts. Pixel order is never disturbed.
- `start` coincident with `done`: ignored. A new `start` is accepted from the cycle after DONE.

## Configuration
- `FRAME_STREAMER_BLANKING_EN` defined:
  - BLANK state present.
  - H_BLANK idle cycles (`pixel_valid`=0) inserted after every line except the last.
- Undefined:
  - BLANK state and its counter absent; H_BLANK ignored.
  - Lines stream back to back.

## Test plan
- Reset, then `start` with a 320x240 ramp (pixel = addr mod 256, prev = ~curr), no pause, blanking off:
  - 76800 valid cycles starting in cycle 3, in order.
  - `pixel_sof` only on pixel 0, 240 `pixel_eol` pulses, `pixel_eof` on pixel 76799.
  - `done` in cycle 76803.
- Blanking on, H_BLANK=16, 8x4 image:
  - 16-cycle `pixel_valid` gaps after lines 0–2 only.
  - `done` 1 cycle after `pixel_eof`; total span 32+48 cycles.
- `pause` pattern high 3 of every 7 cycles, 8x4 image:
  - Output sequence identical to the unpaused run.
  - `pixel_valid` count = 32; no duplicate or skipped addresses.
- `start` pulsed while busy, and again in the DONE cycle:
  - Both ignored; exactly one frame streamed.
  - Third `start` after IDLE streams a second full frame.
- `rst_n` asserted at pixel 1000:
  - All outputs 0 within the same cycle; no `done`.
  - Next `start` restarts at addr 0 with `pixel_sof`.
- Drive into `optical_flow_top_pyramidal` with frame_00/frame_01:
  - Core reaches its done state before the 1,000,000-cycle timeout.

Source files
------------

// File: rtl/frame_pair_streamer.sv
// Raster-order streamer: reads a current/previous frame pair through one shared address
// and emits pixel pairs with SOF/EOL/EOF markers. Optional line blanking: FRAME_STREAMER_BLANKING_EN.
module frame_pair_streamer #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int ADDR_WIDTH   = 17,
    parameter int H_BLANK      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pause,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_curr_data,
    input  logic [7:0]            mem_prev_data,
    output logic [7:0]            pixel_curr,
    output logic [7:0]            pixel_prev,
    output logic                  pixel_valid,
    output logic                  pixel_sof,
    output logic                  pixel_eol,
    output logic                  pixel_eof
);

    localparam int XW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);

    // Elaboration-time guard against an address bus too narrow for the frame.
    if (((longint'(1) << ADDR_WIDTH) < longint'(IMAGE_WIDTH) * IMAGE_HEIGHT) || (H_BLANK < 0)) begin : g_bad_cfg
        $error("frame_pair_streamer: invalid ADDR_WIDTH/H_BLANK configuration");
    end

`ifdef FRAME_STREAMER_BLANKING_EN
    typedef enum logic [2:0] {IDLE, STREAM, BLANK, DRAIN, DONE} state_t;
    localparam int BW = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(H_BLANK - 1);
    logic [BW-1:0] blank_cnt;
`else
    typedef enum logic [2:0] {IDLE, STREAM, DRAIN, DONE} state_t;
`endif

    state_t          state, state_nxt;
    logic [XW-1:0]   x, x_q;
    logic [YW-1:0]   y, y_q;
    logic [ADDR_WIDTH-1:0] addr;
    logic            rd_en;
    logic            rd_q;
    logic            at_eol, at_last;

    assign at_eol  = (x == X_LAST);
    assign at_last = at_eol && (y == Y_LAST);

    assign mem_rd_en = rd_en;
    assign mem_addr  = addr;
    assign done      = (state == DONE);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (!pause) begin
                    rd_en = 1'b1;
                    if (at_last) begin
                        state_nxt = DRAIN;
                    end
`ifdef FRAME_STREAMER_BLANKING_EN
                    else if (at_eol && (H_BLANK > 0)) begin
                        state_nxt = BLANK;
                    end
`endif
                end
            end
`ifdef FRAME_STREAMER_BLANKING_EN
            BLANK: begin
                busy = 1'b1;
                if (blank_cnt == B_LAST) state_nxt = STREAM;
            end
`endif
            DRAIN: begin
                busy = 1'b1;
                // The last read is still in the memory stage while rd_q is high.
                if (!rd_q) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (state == IDLE && start) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (rd_en && !at_last) begin
            addr <= addr + 1'b1;
            if (at_eol) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

`ifdef FRAME_STREAMER_BLANKING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt <= '0;
        end else if (state == BLANK && blank_cnt != B_LAST) begin
            blank_cnt <= blank_cnt + 1'b1;
        end else begin
            blank_cnt <= '0;
        end
    end
`endif

    // Stage 1 tracks the read in the BRAM; stage 2 registers data and markers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q        <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pixel_valid <= 1'b0;
            pixel_sof   <= 1'b0;
            pixel_eol   <= 1'b0;
            pixel_eof   <= 1'b0;
            pixel_curr  <= '0;
            pixel_prev  <= '0;
        end else begin
            rd_q <= rd_en;
            if (rd_en) begin
                x_q <= x;
                y_q <= y;
            end
            pixel_valid <= rd_q;
            pixel_sof   <= rd_q && (x_q == '0) && (y_q == '0);
            pixel_eol   <= rd_q && (x_q == X_LAST);
            pixel_eof   <= rd_q && (x_q == X_LAST) && (y_q == Y_LAST);
            if (rd_q) begin
                pixel_curr <= mem_curr_data;
                pixel_prev <= mem_prev_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_pair_streamer.sv
// Randomized self-checking bench for frame_pair_streamer on a small 8x4 frame; the
// expected pixel stream and read timing come from a frame-level scoreboard.
module tb_frame_pair_streamer;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 5;
    localparam int HB = 3;
`ifdef FRAME_STREAMER_BLANKING_EN
    localparam int HB_EFF = HB;
`else
    localparam int HB_EFF = 0;
`endif
    localparam int EXP_DONE = N + (H - 1) * HB_EFF + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          busy, done, mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_curr_data, mem_prev_data;
    logic [7:0]    pixel_curr, pixel_prev;
    logic          pixel_valid, pixel_sof, pixel_eol, pixel_eof;

    always #5 clk = ~clk;

    frame_pair_streamer #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .ADDR_WIDTH  (AW),
        .H_BLANK     (HB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .pause        (pause),
        .busy         (busy),
        .done         (done),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_curr_data(mem_curr_data),
        .mem_prev_data(mem_prev_data),
        .pixel_curr   (pixel_curr),
        .pixel_prev   (pixel_prev),
        .pixel_valid  (pixel_valid),
        .pixel_sof    (pixel_sof),
        .pixel_eol    (pixel_eol),
        .pixel_eof    (pixel_eof)
    );

    logic [7:0] curr_mem [N];
    logic [7:0] prev_mem [N];

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_curr_data <= curr_mem[mem_addr];
            mem_prev_data <= prev_mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // 0: no pause, 1: high 3 of every 7 cycles, 2: random ~1/3
    int pause_mode = 0;
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            phase = (phase + 1) % 7;
            case (pause_mode)
                1:       pause = (phase < 3);
                2:       pause = ($urandom_range(2) == 0);
                default: pause = 1'b0;
            endcase
        end
    end

    // Scoreboard: pixels must leave in raster order exactly two cycles after their read.
    int exp_idx = 0, rd_idx = 0, valid_cnt = 0;
    int first_valid_cyc = -1, last_valid_cyc = -1, eof_cyc = -1, done_cyc = -1, done_cnt = 0;
    int gap_len[$];
    int gap_at[$];
    int rd_cyc[$];
    logic [7:0] first_prev, eof_curr;

    always @(negedge clk) begin
        bit exp_v;
        if (!rst_n) begin
            check("rst_ctrl", {busy, done, mem_rd_en, pixel_valid, pixel_sof, pixel_eol, pixel_eof}, 0);
            check("rst_addr", mem_addr, 0);
            check("rst_pix", {pixel_curr, pixel_prev}, 0);
            exp_idx = 0;
            rd_idx  = 0;
            rd_cyc.delete();
        end else begin
            while (rd_cyc.size() > 0 && rd_cyc[0] + 2 < cyc) void'(rd_cyc.pop_front());
            exp_v = (rd_cyc.size() > 0) && (rd_cyc[0] + 2 == cyc);
            check("valid_timing", pixel_valid, exp_v);
            if (exp_v) void'(rd_cyc.pop_front());
            if (pixel_valid) begin
                check("pixel_in_frame", exp_idx < N, 1);
                if (exp_idx < N) begin
                    check("pix_curr", pixel_curr, curr_mem[exp_idx]);
                    check("pix_prev", pixel_prev, prev_mem[exp_idx]);
                    check("pix_sof", pixel_sof, exp_idx == 0);
                    check("pix_eol", pixel_eol, (exp_idx % W) == W - 1);
                    check("pix_eof", pixel_eof, exp_idx == N - 1);
                    check("pix_busy", busy, 1);
                end
                if (last_valid_cyc >= 0 && cyc - last_valid_cyc > 1) begin
                    gap_len.push_back(cyc - last_valid_cyc - 1);
                    gap_at.push_back(exp_idx);
                end
                if (first_valid_cyc < 0) begin
                    first_valid_cyc = cyc;
                    first_prev      = pixel_prev;
                end
                if (pixel_eof) begin
                    eof_cyc  = cyc;
                    eof_curr = pixel_curr;
                end
                last_valid_cyc = cyc;
                valid_cnt++;
                exp_idx++;
            end
            if (mem_rd_en) begin
                if (rd_idx == 0) begin
                    valid_cnt       = 0;
                    first_valid_cyc = -1;
                    last_valid_cyc  = -1;
                    eof_cyc         = -1;
                    gap_len.delete();
                    gap_at.delete();
                end
                check("rd_addr", mem_addr, rd_idx);
                check("rd_in_range", rd_idx < N, 1);
                check("rd_while_paused", pause, 0);
                rd_cyc.push_back(cyc);
                rd_idx++;
            end
            if (done) begin
                check("done_all_pixels", exp_idx, N);
                check("done_after_eof", cyc - eof_cyc, 1);
                check("done_not_busy", busy, 0);
                done_cyc = cyc;
                done_cnt++;
                exp_idx = 0;
                rd_idx  = 0;
            end
        end
    end

    task automatic run_frame(input int pmode, input bit poke_busy, input bit poke_done, output int c0);
        int budget;
        int d0;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start      = 1'b1;
        c0         = cyc;
        pause_mode = pmode;
        @(posedge clk);
        #1;
        start  = 1'b0;
        budget = 4000;
        while (done_cnt == d0 && budget > 0) begin
            start = (poke_busy && cyc - c0 == 6) || (poke_done && cyc - c0 == EXP_DONE);
            @(posedge clk);
            #1;
            budget--;
        end
        start      = 1'b0;
        pause_mode = 0;
        check("frame_done_in_budget", done_cnt - d0, 1);
    endtask

    initial begin
        int c0;
        int d0;
        int budget;
        for (int i = 0; i < N; i++) begin
            curr_mem[i] = 8'(i);
            prev_mem[i] = ~8'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_valid", pixel_valid, 0);
        rst_n = 1'b1;

        // Ramp frame, no pause, with a start pulse held during the DONE cycle.
        run_frame(0, 1'b0, 1'b1, c0);
        check("first_valid_rel", first_valid_cyc - c0, 3);
        check("done_rel", done_cyc - c0, EXP_DONE);
        check("eof_rel", eof_cyc - c0, EXP_DONE - 1);
        check("valid_count", valid_cnt, N);
        check("ramp_first_prev", first_prev, 8'hFF);
        check("ramp_eof_curr", eof_curr, 31);
        check("gap_count", gap_len.size(), (HB_EFF > 0) ? H - 1 : 0);
        for (int i = 0; i < gap_len.size(); i++) begin
            check("gap_len", gap_len[i], HB_EFF);
            check("gap_pos", gap_at[i] % W, 0);
        end
        repeat (10) @(posedge clk);
        #1;
        check("start_in_done_ignored_busy", busy, 0);
        check("start_in_done_ignored_reads", rd_idx, 0);
        check("frames_after_a", done_cnt, 1);

        // Random data, periodic pause, a start pulse while busy.
        for (int i = 0; i < N; i++) begin
            curr_mem[i] = 8'($urandom);
            prev_mem[i] = 8'($urandom);
        end
        run_frame(1, 1'b1, 1'b0, c0);
        check("pause7_valid_count", valid_cnt, N);
        check("frames_after_b", done_cnt, 2);

        run_frame(2, 1'b0, 1'b0, c0);
        check("pause_rand_valid_count", valid_cnt, N);
        check("frames_after_c", done_cnt, 3);

        // Reset in the middle of a frame.
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        budget = 500;
        while (exp_idx < 10 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("reach_pixel_10", exp_idx >= 10, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {busy, done, mem_rd_en, pixel_valid, pixel_sof, pixel_eol, pixel_eof}, 0);
        check("midrst_data", {mem_addr, pixel_curr, pixel_prev}, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt, d0);
        check("midrst_idle", busy, 0);

        run_frame(0, 1'b0, 1'b0, c0);
        check("restart_first_valid_rel", first_valid_cyc - c0, 3);
        check("restart_done_rel", done_cyc - c0, EXP_DONE);
        check("restart_valid_count", valid_cnt, N);
        check("restart_first_prev", first_prev, prev_mem[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
